// File: rtl/csa_tree_pkg.sv
// Shared helpers for the carry-save adder tree: operand-count limit and full-adder majority bit.
package csa_tree_pkg;

   localparam int unsigned CSA_MAX_INPUTS = 1024;

   function automatic logic csa_maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: compresses three vectors into a sum vector and a left-shifted carry vector.
module csa_3to2
   import csa_tree_pkg::*;
#(
   parameter int width = 32
) (
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   input  logic [width-1:0] c_i,
   output logic [width-1:0] sum_o,
   output logic [width-1:0] carry_o
);

   always_comb begin
      sum_o   = a_i ^ b_i ^ c_i;
      carry_o = '0;
      // Carry out of the top bit falls off: the tree works modulo 2^width.
      for (int i = 1; i < width; i++) begin
         carry_o[i] = csa_maj(a_i[i-1], b_i[i-1], c_i[i-1]);
      end
   end

endmodule

// File: rtl/csa_tree.sv
// Wallace-style carry-save tree: num_inputs operands -> registered redundant pair (OUT0, OUT1).
// Optional simulation self-check of the modular sum is enabled by defining CSA_TREE_CHECK_EN with verif_en=1.
module csa_tree
   import csa_tree_pkg::*;
#(
   parameter int num_inputs  = 8,
   parameter int input_width = 32,
   parameter int verif_en    = 0
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                valid_i,
   input  logic [num_inputs*input_width-1:0]   INPUT,
   output logic [input_width-1:0]              OUT0,
   output logic [input_width-1:0]              OUT1,
   output logic                                valid_o
);

   function automatic int next_cnt(input int n);
      return (n > 2) ? ((n / 3) * 2 + (n % 3)) : n;
   endfunction

   function automatic int calc_levels(input int n);
      int c;
      int l;
      c = n;
      l = 0;
      for (int i = 0; i < 64; i++) begin
         if (c > 2) begin
            c = next_cnt(c);
            l++;
         end
      end
      return l;
   endfunction

   function automatic int level_cnt(input int n, input int lvl_idx);
      int c;
      c = n;
      for (int i = 0; i < lvl_idx; i++) c = next_cnt(c);
      return c;
   endfunction

   localparam int LEVELS = calc_levels(num_inputs);

   logic [input_width-1:0] lvl [LEVELS+1][num_inputs];
   logic [input_width-1:0] pair_sum;
   logic [input_width-1:0] pair_carry;

   for (genvar j = 0; j < num_inputs; j++) begin : g_in
      assign lvl[0][j] = INPUT[j*input_width +: input_width];
   end

   // Each level: triples compress into (sum, carry) pairs packed first, leftovers follow unchanged.
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int CNT  = level_cnt(num_inputs, l);
      localparam int TRIS = CNT / 3;
      localparam int NXT  = 2 * TRIS + (CNT % 3);

      for (genvar t = 0; t < TRIS; t++) begin : g_csa
         csa_3to2 #(.width(input_width)) u_csa (
            .a_i    (lvl[l][3*t]),
            .b_i    (lvl[l][3*t+1]),
            .c_i    (lvl[l][3*t+2]),
            .sum_o  (lvl[l+1][2*t]),
            .carry_o(lvl[l+1][2*t+1])
         );
      end

      for (genvar j = 2 * TRIS; j < num_inputs; j++) begin : g_pass
         if (j < NXT) begin : g_fwd
            assign lvl[l+1][j] = lvl[l][j+TRIS];
         end else begin : g_zero
            assign lvl[l+1][j] = '0;
         end
      end
   end

   if (num_inputs == 1) begin : g_single
      assign pair_sum   = lvl[LEVELS][0];
      assign pair_carry = '0;
   end else begin : g_pair
      assign pair_sum   = lvl[LEVELS][0];
      assign pair_carry = lvl[LEVELS][1];
   end

   logic [input_width-1:0] out0_d, out0_q;
   logic [input_width-1:0] out1_d, out1_q;
   logic                   valid_d, valid_q;

   always_comb begin
      out0_d  = out0_q;
      out1_d  = out1_q;
      valid_d = valid_i;
      if (valid_i) begin
         out0_d = pair_sum;
         out1_d = pair_carry;
      end
   end

   // Output register stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out0_q  <= '0;
         out1_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         valid_q <= valid_d;
      end
   end

   assign OUT0    = out0_q;
   assign OUT1    = out1_q;
   assign valid_o = valid_q;

`ifdef CSA_TREE_CHECK_EN
`ifndef SYNTHESIS
   if (verif_en != 0) begin : g_check
      logic [input_width-1:0] in_total;
      logic [input_width-1:0] tree_total;

      always_comb begin
         in_total = '0;
         for (int n = 0; n < num_inputs; n++) begin
            in_total = in_total + INPUT[n*input_width +: input_width];
         end
         tree_total = pair_sum + pair_carry;
      end

      always @(posedge clk_i) begin
         if (rst_ni && (in_total !== tree_total)) begin
            $error("%m: csa_tree sum check: inputs=%h tree=%h", in_total, tree_total);
         end
      end
   end
`endif
`else
   // Checker compiled out; verif_en has no effect in this build.
   if (verif_en != 0) begin : g_check_off
   end
`endif

endmodule

// File: tb/tb_csa_tree.sv
// Scoreboard bench for csa_tree: five configurations driven in lock-step, checked on the falling edge.
module tb_csa_tree;

   localparam int EN = 35;

   logic clk;
   logic rst_ni;
   logic valid_i;

   logic [31:0]        a_in;
   logic [47:0]        b_in;
   logic [7:0]         c_in;
   logic [15:0]        d_in;
   logic [EN*64-1:0]   e_in;

   logic [7:0]  a_o0, a_o1, c_o0, c_o1, d_o0, d_o1;
   logic [15:0] b_o0, b_o1;
   logic [63:0] e_o0, e_o1;
   logic        a_vo, b_vo, c_vo, d_vo, e_vo;

   csa_tree #(.num_inputs(4),  .input_width(8),  .verif_en(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .INPUT(a_in),
      .OUT0(a_o0), .OUT1(a_o1), .valid_o(a_vo));
   csa_tree #(.num_inputs(3),  .input_width(16), .verif_en(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .INPUT(b_in),
      .OUT0(b_o0), .OUT1(b_o1), .valid_o(b_vo));
   csa_tree #(.num_inputs(1),  .input_width(8),  .verif_en(1)) dut_c (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .INPUT(c_in),
      .OUT0(c_o0), .OUT1(c_o1), .valid_o(c_vo));
   csa_tree #(.num_inputs(2),  .input_width(8),  .verif_en(1)) dut_d (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .INPUT(d_in),
      .OUT0(d_o0), .OUT1(d_o1), .valid_o(d_vo));
   csa_tree #(.num_inputs(EN), .input_width(64), .verif_en(1)) dut_e (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .INPUT(e_in),
      .OUT0(e_o0), .OUT1(e_o1), .valid_o(e_vo));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  a;
      logic [15:0] b;
      logic [7:0]  c0;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [63:0] e;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   bit   have_last;
   int   checks;
   int   errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_exp(input string tag, input exp_t ex);
      logic [7:0]  a_s;
      logic [15:0] b_s;
      logic [63:0] e_s;
      a_s = a_o0 + a_o1;
      b_s = b_o0 + b_o1;
      e_s = e_o0 + e_o1;
      chk({tag, "_a_sum"}, 64'(a_s), 64'(ex.a));
      chk({tag, "_b_sum"}, 64'(b_s), 64'(ex.b));
      chk({tag, "_c_out0"}, 64'(c_o0), 64'(ex.c0));
      chk({tag, "_c_out1"}, 64'(c_o1), 64'h0);
      chk({tag, "_d_out0"}, 64'(d_o0), 64'(ex.d0));
      chk({tag, "_d_out1"}, 64'(d_o1), 64'(ex.d1));
      chk({tag, "_e_sum"}, e_s, ex.e);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_a"}, {48'h0, a_o0, a_o1}, 64'h0);
      chk({tag, "_b"}, {32'h0, b_o0, b_o1}, 64'h0);
      chk({tag, "_cd"}, {32'h0, c_o0, c_o1, d_o0, d_o1}, 64'h0);
      chk({tag, "_e0"}, e_o0, 64'h0);
      chk({tag, "_e1"}, e_o1, 64'h0);
      chk({tag, "_valid"}, 64'({a_vo, b_vo, c_vo, d_vo, e_vo}), 64'h0);
   endtask

   // Monitor: every falling edge out of reset, valid_o must match scoreboard occupancy.
   always @(negedge clk) begin
      if (rst_ni) begin
         if (exp_q.size() != 0) begin
            chk("valid_o", 64'({a_vo, b_vo, c_vo, d_vo, e_vo}), 64'h1f);
            last_exp  = exp_q.pop_front();
            have_last = 1'b1;
            chk_exp("result", last_exp);
         end else begin
            chk("valid_o_idle", 64'({a_vo, b_vo, c_vo, d_vo, e_vo}), 64'h0);
            if (have_last) chk_exp("hold", last_exp);
         end
      end
   end

   task automatic send(input bit vld, input exp_t ex);
      valid_i = vld;
      @(posedge clk);
      if (vld) exp_q.push_back(ex);
      #1;
   endtask

   task automatic rand_inputs(output exp_t ex);
      ex = '0;
      for (int k = 0; k < 4; k++) begin
         a_in[k*8 +: 8] = 8'($urandom);
         ex.a = ex.a + a_in[k*8 +: 8];
      end
      for (int k = 0; k < 3; k++) begin
         b_in[k*16 +: 16] = 16'($urandom);
         ex.b = ex.b + b_in[k*16 +: 16];
      end
      c_in  = 8'($urandom);
      d_in  = 16'($urandom);
      ex.c0 = c_in;
      ex.d0 = d_in[7:0];
      ex.d1 = d_in[15:8];
      for (int k = 0; k < EN; k++) begin
         e_in[k*64 +: 64] = {$urandom, $urandom};
         ex.e = ex.e + e_in[k*64 +: 64];
      end
   endtask

   logic [31:0] ta_in  [5];
   logic [7:0]  ta_exp [5];
   logic [47:0] tb_in  [5];
   logic [15:0] tb_exp [5];
   logic [7:0]  tc_in  [5];
   logic [15:0] td_in  [5];
   logic [63:0] te_v   [5];
   logic [63:0] te_exp [5];

   task automatic load_vec(input int i, output exp_t ex);
      a_in = ta_in[i];
      b_in = tb_in[i];
      c_in = tc_in[i];
      d_in = td_in[i];
      for (int k = 0; k < EN; k++) e_in[k*64 +: 64] = te_v[i];
      ex.a  = ta_exp[i];
      ex.b  = tb_exp[i];
      ex.c0 = tc_in[i];
      ex.d0 = td_in[i][7:0];
      ex.d1 = td_in[i][15:8];
      ex.e  = te_exp[i];
   endtask

   initial begin
      exp_t ex;
      checks    = 0;
      errors    = 0;
      have_last = 1'b0;

      ta_in[0] = 32'hFFFF_FFFF; ta_exp[0] = 8'hFC;
      tb_in[0] = {16'h0003, 16'h0002, 16'h0001}; tb_exp[0] = 16'h0006;
      tc_in[0] = 8'h5A; td_in[0] = {8'h33, 8'h5A};
      te_v[0]  = 64'h1; te_exp[0] = 64'h23;
      ta_in[1] = 32'h0403_0201; ta_exp[1] = 8'h0A;
      tb_in[1] = {16'h0002, 16'hFFFF, 16'hFFFF}; tb_exp[1] = 16'h0000;
      tc_in[1] = 8'h00; td_in[1] = {8'h01, 8'hFF};
      te_v[1]  = 64'hFFFF_FFFF_FFFF_FFFF; te_exp[1] = 64'hFFFF_FFFF_FFFF_FFDD;
      ta_in[2] = 32'h8080_8080; ta_exp[2] = 8'h00;
      tb_in[2] = {16'h1234, 16'h8000, 16'h8000}; tb_exp[2] = 16'h1234;
      tc_in[2] = 8'hFF; td_in[2] = {8'hFF, 8'h00};
      te_v[2]  = 64'h8000_0000_0000_0000; te_exp[2] = 64'h8000_0000_0000_0000;
      ta_in[3] = 32'h7856_3412; ta_exp[3] = 8'h14;
      tb_in[3] = {16'h0000, 16'h5555, 16'hAAAA}; tb_exp[3] = 16'hFFFF;
      tc_in[3] = 8'h01; td_in[3] = {8'h80, 8'h80};
      te_v[3]  = 64'h10; te_exp[3] = 64'h230;
      ta_in[4] = 32'h0; ta_exp[4] = 8'h00;
      tb_in[4] = 48'h0; tb_exp[4] = 16'h0000;
      tc_in[4] = 8'hA5; td_in[4] = 16'h0000;
      te_v[4]  = 64'h0; te_exp[4] = 64'h0;

      // Reset held with valid inputs applied
      rst_ni  = 1'b0;
      valid_i = 1'b1;
      rand_inputs(ex);
      repeat (2) begin
         @(negedge clk);
         chk_reset("reset");
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      rst_ni  = 1'b1;

      for (int i = 0; i < 5; i++) begin
         load_vec(i, ex);
         send(1'b1, ex);
      end

      // Hold: one capture, then idle cycles with changing inputs
      load_vec(3, ex);
      send(1'b1, ex);
      for (int i = 0; i < 3; i++) begin
         load_vec(i, ex);
         send(1'b0, ex);
      end

      // Asynchronous reset between edges discards the captured result
      load_vec(0, ex);
      send(1'b1, ex);
      #2;
      rst_ni = 1'b0;
      exp_q.delete();
      have_last = 1'b0;
      #1;
      chk_reset("async_reset");
      @(negedge clk);
      chk_reset("async_reset_held");
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      rst_ni  = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10000; i++) begin
         rand_inputs(ex);
         send(1'b1, ex);
      end
      rand_inputs(ex);
      send(1'b0, ex);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
